// File: rtl/responder_arbiter_if.sv
// Round-controller bus: host controls, contestant buttons and timer handshake
// in one direction, round status back out to the display and timer block.
interface responder_arbiter_if #(
    parameter int N_PLAYERS = 4,
    parameter int ID_W      = 3
);
    logic                 host_arm;
    logic                 host_go;
    logic                 host_clear;
    logic [N_PLAYERS-1:0] btn;
    logic                 timer_end;
    logic                 timer_start;
    logic                 timer_stop;
    logic                 winner_valid;
    logic [ID_W-1:0]      winner_id;
    logic [N_PLAYERS-1:0] foul_mask;
    logic                 timeout;
    logic                 buzz;
    logic [2:0]           state_dbg;

    modport master (
        output host_arm, host_go, host_clear, btn, timer_end,
        input  timer_start, timer_stop, winner_valid, winner_id,
               foul_mask, timeout, buzz, state_dbg
    );

    modport slave (
        input  host_arm, host_go, host_clear, btn, timer_end,
        output timer_start, timer_stop, winner_valid, winner_id,
               foul_mask, timeout, buzz, state_dbg
    );
endinterface

// File: rtl/responder_arbiter.sv
// Quiz round controller: sequences the countdown timer, latches exactly one
// winner per round, flags early presses as fouls and drives the buzzer.
module responder_arbiter #(
    parameter int N_PLAYERS   = 4,
    parameter int ID_W        = 3,
    parameter int BUZZ_CYCLES = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    responder_arbiter_if.slave   bus
);
    localparam int SYNC_W = N_PLAYERS + 3;
    localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES);
    localparam logic [BUZZ_W-1:0] BUZZ_ONE  = BUZZ_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUNNING = 3'd2,
        LOCKED  = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    state_t               state_reg;
    logic                 timer_start_reg;
    logic                 timer_stop_reg;
    logic                 winner_valid_reg;
    logic [ID_W-1:0]      winner_id_reg;
    logic [N_PLAYERS-1:0] foul_mask_reg;
    logic                 timeout_reg;
    logic [BUZZ_W-1:0]    buzz_cnt_reg;

    logic [SYNC_W-1:0]    raw_in;
    logic [SYNC_W-1:0]    sync1_reg;
    logic [SYNC_W-1:0]    sync2_reg;
    logic [SYNC_W-1:0]    prev_reg;
    logic [SYNC_W-1:0]    rise;
    logic [N_PLAYERS-1:0] btn_rise;
    logic [N_PLAYERS-1:0] eligible;
    logic                 arm_rise;
    logic                 go_rise;
    logic                 clear_rise;
    logic                 any_eligible;
    logic [ID_W-1:0]      first_id;

    // Buttons and host controls share one synchronizer/edge-detect pipeline.
    assign raw_in = {bus.host_clear, bus.host_go, bus.host_arm, bus.btn};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise       = sync2_reg & ~prev_reg;
    assign btn_rise   = rise[N_PLAYERS-1:0];
    assign arm_rise   = rise[N_PLAYERS];
    assign go_rise    = rise[N_PLAYERS+1];
    assign clear_rise = rise[N_PLAYERS+2];

    // A player who fouled during ARMED cannot win this round.
    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_elig
        assign eligible[gi] = btn_rise[gi] & ~foul_mask_reg[gi];
    end

    assign any_eligible = |eligible;

    always_comb begin
        first_id = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) first_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            timer_start_reg  <= 1'b0;
            timer_stop_reg   <= 1'b0;
            winner_valid_reg <= 1'b0;
            winner_id_reg    <= '0;
            foul_mask_reg    <= '0;
            timeout_reg      <= 1'b0;
            buzz_cnt_reg     <= '0;
        end else begin
            timer_stop_reg <= 1'b0;
            if (buzz_cnt_reg != '0) buzz_cnt_reg <= buzz_cnt_reg - BUZZ_ONE;

            if (clear_rise && state_reg != IDLE) begin
                state_reg       <= IDLE;
                timer_start_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (arm_rise) begin
                            state_reg        <= ARMED;
                            foul_mask_reg    <= '0;
                            winner_valid_reg <= 1'b0;
                            winner_id_reg    <= '0;
                            timeout_reg      <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (btn_rise != '0) begin
                            foul_mask_reg <= foul_mask_reg | btn_rise;
                            buzz_cnt_reg  <= BUZZ_LOAD;
                        end
                        if (go_rise) begin
                            state_reg       <= RUNNING;
                            timer_start_reg <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        // A valid press beats a simultaneous timer expiry.
                        if (any_eligible) begin
                            state_reg        <= LOCKED;
                            timer_start_reg  <= 1'b0;
                            timer_stop_reg   <= 1'b1;
                            winner_valid_reg <= 1'b1;
                            winner_id_reg    <= first_id;
                            buzz_cnt_reg     <= BUZZ_LOAD;
                        end else if (bus.timer_end) begin
                            state_reg       <= TIMEOUT;
                            timer_start_reg <= 1'b0;
                            timeout_reg     <= 1'b1;
                            buzz_cnt_reg    <= BUZZ_LOAD;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.timer_start  = timer_start_reg;
    assign bus.timer_stop   = timer_stop_reg;
    assign bus.winner_valid = winner_valid_reg;
    assign bus.winner_id    = winner_id_reg;
    assign bus.foul_mask    = foul_mask_reg;
    assign bus.timeout      = timeout_reg;
    assign bus.buzz         = (buzz_cnt_reg != '0);
    assign bus.state_dbg    = state_reg;
endmodule

// File: tb/tb_responder_arbiter.sv
// Bench for responder_arbiter: directed round scenarios plus randomized
// stimulus compared cycle by cycle against an event-level round model.
module tb_responder_arbiter;
    localparam int N    = 4;
    localparam int IDW  = 3;
    localparam int BUZZ = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    responder_arbiter_if #(.N_PLAYERS(N), .ID_W(IDW)) bus ();

    responder_arbiter #(.N_PLAYERS(N), .ID_W(IDW), .BUZZ_CYCLES(BUZZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Round model: phase codes are the reported state numbers.
    logic [2:0] m_phase;
    logic       m_wv;
    logic [2:0] m_wid;
    logic [3:0] m_foul;
    logic       m_tmo;
    logic       m_stop;
    int         cyc = 0;
    int         last_trig = -1000;
    logic [6:0] h1, h2, h3;

    task automatic model_step();
        logic [6:0] cur;
        logic [6:0] r;
        logic [3:0] elig;
        cur = {bus.host_clear, bus.host_go, bus.host_arm, bus.btn};
        cyc++;
        m_stop = 1'b0;
        if (rst) begin
            m_phase = 3'd0; m_wv = 1'b0; m_wid = 3'd0; m_foul = 4'd0; m_tmo = 1'b0;
            last_trig = cyc - 1000;
            h1 = '0; h2 = '0; h3 = '0;
        end else begin
            // An input seen rising two samples ago acts on this edge.
            r = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = cur;
            if (r[6] && m_phase != 3'd0) begin
                m_phase = 3'd0;
            end else if (m_phase == 3'd0) begin
                if (r[4]) begin
                    m_phase = 3'd1; m_foul = 4'd0; m_wv = 1'b0; m_wid = 3'd0; m_tmo = 1'b0;
                end
            end else if (m_phase == 3'd1) begin
                if (r[3:0] != 4'd0) begin
                    m_foul = m_foul | r[3:0];
                    last_trig = cyc;
                end
                if (r[5]) m_phase = 3'd2;
            end else if (m_phase == 3'd2) begin
                elig = r[3:0] & ~m_foul;
                if (elig != 4'd0) begin
                    for (int i = 0; i < N; i++) begin
                        if (elig[i]) begin
                            m_wid = 3'(i);
                            break;
                        end
                    end
                    m_wv = 1'b1; m_stop = 1'b1; m_phase = 3'd3; last_trig = cyc;
                end else if (bus.timer_end) begin
                    m_phase = 3'd4; m_tmo = 1'b1; last_trig = cyc;
                end
            end
        end
    endtask

    function automatic logic m_buzz();
        return (cyc - last_trig) < BUZZ;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: bus.host_arm = 1'b1;
            1: bus.host_go = 1'b1;
            default: bus.host_clear = 1'b1;
        endcase
        repeat (4) tick();
        bus.host_arm = 1'b0; bus.host_go = 1'b0; bus.host_clear = 1'b0;
        repeat (2) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.timer_start, bus.timer_stop, bus.winner_valid, bus.winner_id, bus.foul_mask,
             bus.timeout, bus.buzz, bus.state_dbg} !== 15'd0)
            begin failures++; $display("FAIL reset_outputs got st=%0d wv=%0d buzz=%0d req all 0",
                bus.state_dbg, bus.winner_valid, bus.buzz); end
    endtask

    task automatic test_single_winner();
        int lat = 0;
        int stop_cnt;
        int buzz_cnt;
        apply_reset();
        pulse(0);
        pulse(1);
        checks++;
        if (bus.state_dbg !== 3'd2 || bus.timer_start !== 1'b1)
            begin failures++; $display("FAIL running_entry got st=%0d ts=%0d req st=2 ts=1",
                bus.state_dbg, bus.timer_start); end
        bus.btn = 4'b0100;
        while (bus.winner_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
            bus.btn = 4'b0000;
        end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL press_latency got=%0d req=3", lat); end
        stop_cnt = int'(bus.timer_stop);
        buzz_cnt = int'(bus.buzz);
        repeat (12) begin
            tick();
            stop_cnt += int'(bus.timer_stop);
            buzz_cnt += int'(bus.buzz);
        end
        checks++;
        if (bus.winner_id !== 3'd2) begin failures++; $display("FAIL single_winner_id got=%0d req=2", bus.winner_id); end
        checks++;
        if (stop_cnt != 1) begin failures++; $display("FAIL timer_stop_pulses got=%0d req=1", stop_cnt); end
        checks++;
        if (buzz_cnt != BUZZ) begin failures++; $display("FAIL buzz_length got=%0d req=%0d", buzz_cnt, BUZZ); end
        checks++;
        if (bus.timer_start !== 1'b0 || bus.state_dbg !== 3'd3)
            begin failures++; $display("FAIL locked_state got st=%0d ts=%0d req st=3 ts=0",
                bus.state_dbg, bus.timer_start); end
    endtask

    task automatic test_foul();
        apply_reset();
        pulse(0);
        bus.btn = 4'b0010; tick(); bus.btn = 4'b0000;
        repeat (3) tick();
        checks++;
        if (bus.foul_mask !== 4'b0010 || bus.buzz !== 1'b1)
            begin failures++; $display("FAIL foul_armed got mask=%b buzz=%0d req mask=0010 buzz=1",
                bus.foul_mask, bus.buzz); end
        pulse(1);
        bus.btn = 4'b0010; tick(); bus.btn = 4'b0000;
        repeat (4) tick();
        checks++;
        if (bus.winner_valid !== 1'b0 || bus.state_dbg !== 3'd2)
            begin failures++; $display("FAIL fouled_player_ignored got wv=%0d st=%0d req wv=0 st=2",
                bus.winner_valid, bus.state_dbg); end
        bus.btn = 4'b1000; tick(); bus.btn = 4'b0000;
        repeat (4) tick();
        checks++;
        if (bus.winner_valid !== 1'b1 || bus.winner_id !== 3'd3 || bus.foul_mask !== 4'b0010)
            begin failures++; $display("FAIL foul_then_winner got wv=%0d id=%0d mask=%b req wv=1 id=3 mask=0010",
                bus.winner_valid, bus.winner_id, bus.foul_mask); end
    endtask

    task automatic test_tie();
        apply_reset();
        pulse(0);
        pulse(1);
        bus.btn = 4'b1001; tick(); bus.btn = 4'b0000;
        repeat (4) tick();
        checks++;
        if (bus.winner_valid !== 1'b1 || bus.winner_id !== 3'd0)
            begin failures++; $display("FAIL tie_lowest got wv=%0d id=%0d req wv=1 id=0",
                bus.winner_valid, bus.winner_id); end
        bus.btn = 4'b0110; tick(); bus.btn = 4'b0000;
        repeat (4) tick();
        checks++;
        if (bus.winner_id !== 3'd0 || bus.state_dbg !== 3'd3 || bus.foul_mask !== 4'd0)
            begin failures++; $display("FAIL locked_ignores_btn got id=%0d st=%0d mask=%b req id=0 st=3 mask=0000",
                bus.winner_id, bus.state_dbg, bus.foul_mask); end
    endtask

    task automatic test_timeout();
        apply_reset();
        pulse(0);
        pulse(1);
        bus.timer_end = 1'b1; tick(); bus.timer_end = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.state_dbg !== 3'd4 || bus.timeout !== 1'b1 || bus.winner_valid !== 1'b0 ||
            bus.timer_start !== 1'b0 || bus.buzz !== 1'b1)
            begin failures++; $display("FAIL timeout_state got st=%0d to=%0d wv=%0d ts=%0d buzz=%0d req 4/1/0/0/1",
                bus.state_dbg, bus.timeout, bus.winner_valid, bus.timer_start, bus.buzz); end
        pulse(2);
        checks++;
        if (bus.state_dbg !== 3'd0 || bus.timeout !== 1'b1)
            begin failures++; $display("FAIL clear_keeps_status got st=%0d to=%0d req st=0 to=1",
                bus.state_dbg, bus.timeout); end
        pulse(0);
        checks++;
        if (bus.state_dbg !== 3'd1 || bus.timeout !== 1'b0)
            begin failures++; $display("FAIL arm_clears_status got st=%0d to=%0d req st=1 to=0",
                bus.state_dbg, bus.timeout); end
        pulse(1);
        bus.btn = 4'b0001; tick();
        bus.btn = 4'b0000; tick();
        bus.timer_end = 1'b1; tick(); bus.timer_end = 1'b0;
        checks++;
        if (bus.state_dbg !== 3'd3 || bus.winner_id !== 3'd0 || bus.timeout !== 1'b0)
            begin failures++; $display("FAIL press_beats_timer got st=%0d id=%0d to=%0d req st=3 id=0 to=0",
                bus.state_dbg, bus.winner_id, bus.timeout); end
    endtask

    task automatic test_reset_midround();
        apply_reset();
        pulse(0);
        bus.btn = 4'b0100; bus.host_go = 1'b1; tick();
        bus.btn = 4'b0000;
        repeat (2) tick();
        checks++;
        if (bus.state_dbg !== 3'd2 || bus.buzz !== 1'b1 || bus.foul_mask !== 4'b0100)
            begin failures++; $display("FAIL run_with_buzz got st=%0d buzz=%0d mask=%b req st=2 buzz=1 mask=0100",
                bus.state_dbg, bus.buzz, bus.foul_mask); end
        bus.host_go = 1'b0;
        apply_reset();
        checks++;
        if ({bus.timer_start, bus.timer_stop, bus.winner_valid, bus.winner_id, bus.foul_mask,
             bus.timeout, bus.buzz, bus.state_dbg} !== 15'd0)
            begin failures++; $display("FAIL midround_reset got st=%0d buzz=%0d mask=%b ts=%0d req all 0",
                bus.state_dbg, bus.buzz, bus.foul_mask, bus.timer_start); end
        pulse(0);
        bus.host_clear = 1'b1; bus.host_go = 1'b1;
        repeat (4) tick();
        bus.host_clear = 1'b0; bus.host_go = 1'b0;
        checks++;
        if (bus.state_dbg !== 3'd0 || bus.timer_start !== 1'b0)
            begin failures++; $display("FAIL clear_beats_go got st=%0d ts=%0d req st=0 ts=0",
                bus.state_dbg, bus.timer_start); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 299) == 0);
            bus.host_arm   = ($urandom_range(0, 3) == 0);
            bus.host_go    = ($urandom_range(0, 3) == 0);
            bus.host_clear = ($urandom_range(0, 39) == 0);
            for (int b = 0; b < N; b++) bus.btn[b] = ($urandom_range(0, 4) == 0);
            bus.timer_end  = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (bus.state_dbg !== m_phase) begin failures++;
                $display("FAIL rnd_state cyc=%0d got=%0d req=%0d", cyc, bus.state_dbg, m_phase); end
            checks++;
            if (bus.timer_start !== (m_phase == 3'd2)) begin failures++;
                $display("FAIL rnd_timer_start cyc=%0d got=%0d req=%0d", cyc, bus.timer_start, m_phase == 3'd2); end
            checks++;
            if (bus.timer_stop !== m_stop) begin failures++;
                $display("FAIL rnd_timer_stop cyc=%0d got=%0d req=%0d", cyc, bus.timer_stop, m_stop); end
            checks++;
            if (bus.winner_valid !== m_wv || bus.winner_id !== m_wid) begin failures++;
                $display("FAIL rnd_winner cyc=%0d got=%0d/%0d req=%0d/%0d", cyc, bus.winner_valid,
                    bus.winner_id, m_wv, m_wid); end
            checks++;
            if (bus.foul_mask !== m_foul) begin failures++;
                $display("FAIL rnd_foul cyc=%0d got=%b req=%b", cyc, bus.foul_mask, m_foul); end
            checks++;
            if (bus.timeout !== m_tmo) begin failures++;
                $display("FAIL rnd_timeout cyc=%0d got=%0d req=%0d", cyc, bus.timeout, m_tmo); end
            checks++;
            if (bus.buzz !== m_buzz()) begin failures++;
                $display("FAIL rnd_buzz cyc=%0d got=%0d req=%0d", cyc, bus.buzz, m_buzz()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.host_arm = 1'b0; bus.host_go = 1'b0; bus.host_clear = 1'b0;
        bus.btn = '0; bus.timer_end = 1'b0;
        test_reset();
        test_single_winner();
        test_foul();
        test_tie();
        test_timeout();
        test_reset_midround();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/responder_arbiter.md
Name: responder_arbiter

Overview:
Round controller for the quiz responder. Sequences the countdown timer (start/stop/expiry) and arbitrates N contestant buttons so that exactly one winner is latched per round. Flags early presses as fouls, drives a buzzer pulse, and reports winner/timeout status to the display logic. Sits between the host/contestant button inputs and the timer block.

Parameters:
N_PLAYERS, 4, number of contestant buttons (2..8)
ID_W, 3, width of winner_id; must satisfy 2^ID_W >= N_PLAYERS
BUZZ_CYCLES, 25000000, buzzer pulse length in clk cycles (0.25 s at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
host_arm  in  1  host opens a round (level; rising edge acts)
host_go  in  1  host starts answering window (level; rising edge acts)
host_clear  in  1  host ends round, returns to IDLE (level; rising edge acts)
btn  in  N_PLAYERS  raw contestant buttons, asynchronous, active-high
timer_end  in  1  timer expiry flag (count == 0)
timer_start  out  1  to timer start input; 0 = hold/reload, 1 = count down
timer_stop  out  1  to timer stop input; 1-cycle reload pulse
winner_valid  out  1  a winner is latched
winner_id  out  ID_W  index of winner, valid when winner_valid
foul_mask  out  N_PLAYERS  bit i set = player i pressed early this round
timeout  out  1  window expired with no winner
buzz  out  1  buzzer drive
state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; all outputs 0; sync/edge registers 0; buzz counter 0. Reset mid-round aborts immediately.
- Inputs: btn and host_* each pass through 2-flop synchronizer, then a registered previous-value for rising-edge detect. Press-to-action latency: btn high before edge t0 -> action registered at edge t2 (visible after 3rd edge).
- States: IDLE=0, ARMED=1, RUNNING=2, LOCKED=3, TIMEOUT=4.
- IDLE: timer_start=0. host_arm rise -> ARMED, clear foul_mask, winner_valid, winner_id, timeout.
- ARMED: timer_start=0. btn[i] rise -> foul_mask[i]<=1, start buzz pulse. host_go rise -> RUNNING.
- RUNNING: timer_start=1. Eligible rises = btn rises & ~foul_mask. Any eligible -> LOCKED, winner_id = lowest eligible index, winner_valid<=1, timer_stop pulse 1 cycle, buzz pulse. Else if timer_end=1 -> TIMEOUT, timeout<=1, buzz pulse. Same-cycle eligible press and timer_end: press wins.
- If all players fouled, RUNNING still waits for timer_end.
- LOCKED, TIMEOUT: timer_start=0; all btn edges ignored (no new fouls, no winner change).
- host_clear rise in any non-IDLE state -> IDLE (outputs cleared on next host_arm, not on clear); highest priority over all other events in the same cycle. host_arm/host_go in wrong states ignored.
- Buzzer: counter loaded with BUZZ_CYCLES on any trigger; buzz=1 while counter != 0; retrigger reloads. Counter width = clog2(BUZZ_CYCLES+1).
- timer_end sampled directly (already synchronous to clk); ignored outside RUNNING.

Test Plan:
- Reset then arm, go, btn[2] pulse -> winner_valid=1, winner_id=2 three edges later, timer_stop one 1-cycle pulse, timer_start 0, buzz high BUZZ_CYCLES (bench BUZZ_CYCLES=8).
- Arm, btn[1] press while ARMED, go, btn[1] then btn[3] -> foul_mask=4'b0010, btn[1] ignored in RUNNING, winner_id=3.
- Arm, go, btn[3] and btn[0] rise same cycle -> winner_id=0; later btn presses leave winner_id=0.
- Arm, go, no presses, assert timer_end -> state TIMEOUT, timeout=1, winner_valid=0; timer_end and eligible press same cycle -> LOCKED instead.
- Assert rst in RUNNING with buzz active -> next edge all outputs 0, state_dbg=0; host_clear with host_go same cycle in ARMED -> IDLE.
